// File: rtl/mem_stage_sram_ctrl.sv
// ARM pipeline memory stage: splits each 32-bit load/store into two 16-bit SRAM
// accesses with programmable wait states, freezing the pipeline while busy.
module mem_stage_sram_ctrl #(
    parameter int          SRAM_ADDR_W = 18,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_OFFSET = 32'd1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en_in,
    input  logic                   mem_r_en_in,
    input  logic                   mem_w_en_in,
    input  logic [31:0]            alu_res_in,
    input  logic [31:0]            val_r_m_in,
    input  logic [3:0]             dest_in,
    output logic                   wb_en_out,
    output logic                   mem_r_en_out,
    output logic [31:0]            alu_res_out,
    output logic [3:0]             dest_out,
    output logic [31:0]            mem_data_out,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_wdata,
    input  logic [15:0]            sram_rdata,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [15:0]            low_q, low_d;
    logic [31:0]            mem_data_q, mem_data_d;

    logic                   req;
    logic                   is_store;
    logic                   is_load;
    logic                   cnt_last;
    logic [31:0]            byte_off;
    logic [SRAM_ADDR_W-2:0] word_addr;
    logic                   unused_addr_bits;

    assign wb_en_out    = wb_en_in;
    assign mem_r_en_out = mem_r_en_in;
    assign alu_res_out  = alu_res_in;
    assign dest_out     = dest_in;
    assign mem_data_out = mem_data_q;

    // A store wins when both enables are set; the load request is dropped.
    assign req      = mem_r_en_in | mem_w_en_in;
    assign is_store = mem_w_en_in;
    assign is_load  = mem_r_en_in & ~mem_w_en_in;
    assign cnt_last = (cnt_q == CNT_LAST);

    // Word index wraps silently into the SRAM; byte lane bits are ignored.
    assign byte_off         = alu_res_in - ADDR_OFFSET;
    assign word_addr        = byte_off[SRAM_ADDR_W:2];
    assign unused_addr_bits = ^{byte_off[31:SRAM_ADDR_W+1], byte_off[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        low_d      = low_q;
        mem_data_d = mem_data_q;
        ready      = 1'b1;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_addr  = '0;
        sram_wdata = '0;

        case (state_q)
            S_IDLE: begin
                ready = ~req;
                if (req) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end
            end
            S_LOW: begin
                ready     = 1'b0;
                sram_addr = {word_addr, 1'b0};
                if (is_store) begin
                    sram_we_n  = 1'b0;
                    sram_wdata = val_r_m_in[15:0];
                end else if (is_load) begin
                    sram_oe_n = 1'b0;
                end
                if (cnt_last) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    if (is_load) begin
                        low_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                ready     = 1'b0;
                sram_addr = {word_addr, 1'b1};
                if (is_store) begin
                    sram_we_n  = 1'b0;
                    sram_wdata = val_r_m_in[31:16];
                end else if (is_load) begin
                    sram_oe_n = 1'b0;
                end
                if (cnt_last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (is_load) begin
                        mem_data_d = {sram_rdata, low_q};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // The pipeline advances on this edge; the next instruction is seen in IDLE.
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            low_q      <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            low_q      <= low_d;
            mem_data_q <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: default instance (WAIT_CYCLES=2) and a
// WAIT_CYCLES=1 instance share stimulus, each with its own SRAM model.
module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_res_in, val_r_m_in;
    logic [3:0]  dest_in;

    logic        wb_en_out, mem_r_en_out, ready, sram_we_n, sram_oe_n;
    logic [31:0] alu_res_out, mem_data_out;
    logic [3:0]  dest_out;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;

    logic        wb_en_out1, mem_r_en_out1, ready1, sram_we_n1, sram_oe_n1;
    logic [31:0] alu_res_out1, mem_data_out1;
    logic [3:0]  dest_out1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_wdata1, sram_rdata1;

    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] model_md0, model_md1;

    logic        tr_we   [0:63];
    logic        tr_oe   [0:63];
    logic [17:0] tr_addr [0:63];
    logic [15:0] tr_wd   [0:63];

    always #5 clk = ~clk;

    mem_stage_sram_ctrl dut (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .val_r_m_in(val_r_m_in), .dest_in(dest_in),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
        .dest_out(dest_out), .mem_data_out(mem_data_out), .ready(ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    mem_stage_sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .val_r_m_in(val_r_m_in), .dest_in(dest_in),
        .wb_en_out(wb_en_out1), .mem_r_en_out(mem_r_en_out1), .alu_res_out(alu_res_out1),
        .dest_out(dest_out1), .mem_data_out(mem_data_out1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1),
        .sram_we_n(sram_we_n1), .sram_oe_n(sram_oe_n1)
    );

    always @(posedge clk) begin
        if (!sram_we_n)  mem0[sram_addr[7:0]]  <= sram_wdata;
        if (!sram_we_n1) mem1[sram_addr1[7:0]] <= sram_wdata1;
    end
    assign sram_rdata  = sram_oe_n  ? 16'h0000 : mem0[sram_addr[7:0]];
    assign sram_rdata1 = sram_oe_n1 ? 16'h0000 : mem1[sram_addr1[7:0]];

    task automatic idle_inputs();
        wb_en_in    = 1'b0;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
        alu_res_in  = 32'h0;
        val_r_m_in  = 32'h0;
        dest_in     = 4'h0;
    endtask

    // Drives one access, counts freeze cycles until ready, records SRAM pins per
    // cycle, and checks mem_data_out against the scoreboard at DONE.
    task automatic run_mem(input bit sel1, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] load_word, input int exp_low, input string name);
        int          n_low;
        bit          done;
        logic [31:0] exp_md;
        logic [31:0] got_md;
        wb_en_in    = rd;
        mem_r_en_in = rd;
        mem_w_en_in = wr;
        alu_res_in  = addr;
        val_r_m_in  = data;
        dest_in     = 4'd1;
        if (rd && !wr) begin
            if (sel1) model_md1 = load_word;
            else      model_md0 = load_word;
        end
        sb_q.push_back(sel1 ? model_md1 : model_md0);
        n_low = 0;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            tr_we[i]   = sel1 ? sram_we_n1  : sram_we_n;
            tr_oe[i]   = sel1 ? sram_oe_n1  : sram_oe_n;
            tr_addr[i] = sel1 ? sram_addr1  : sram_addr;
            tr_wd[i]   = sel1 ? sram_wdata1 : sram_wdata;
            if (sel1 ? ready1 : ready) done = 1'b1;
            else                       n_low++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout ready never rose within 40 cycles", name);
        end
        checks++;
        if (n_low !== exp_low) begin
            errors++;
            $display("FAIL %s_freeze_cycles got %0d want %0d", name, n_low, exp_low);
        end
        exp_md = sb_q.pop_front();
        got_md = sel1 ? mem_data_out1 : mem_data_out;
        checks++;
        if (got_md !== exp_md) begin
            errors++;
            $display("FAIL %s_mem_data got %h want %h", name, got_md, exp_md);
        end
        @(posedge clk);
        #1;
    endtask

    // Checks the recorded per-cycle SRAM pins of a default-instance access.
    task automatic check_trace(input bit store, input logic [17:0] base, input logic [31:0] data,
                               input string name);
        logic        e_we, e_oe;
        logic [17:0] e_addr;
        logic [15:0] e_wd;
        for (int i = 0; i < 6; i++) begin
            e_we = 1'b1; e_oe = 1'b1; e_addr = 18'd0; e_wd = 16'h0;
            if (i >= 1 && i <= 4) begin
                e_addr = (i <= 2) ? base : base + 18'd1;
                if (store) begin
                    e_we = 1'b0;
                    e_wd = (i <= 2) ? data[15:0] : data[31:16];
                end else begin
                    e_oe = 1'b0;
                end
            end
            checks++;
            if (tr_we[i] !== e_we || tr_oe[i] !== e_oe || tr_addr[i] !== e_addr || tr_wd[i] !== e_wd) begin
                errors++;
                $display("FAIL %s_pins cyc%0d got we=%b oe=%b addr=%0d wd=%h want we=%b oe=%b addr=%0d wd=%h",
                         name, i, tr_we[i], tr_oe[i], tr_addr[i], tr_wd[i], e_we, e_oe, e_addr, e_wd);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b we=%b oe=%b want 1 1 1", ready, sram_we_n, sram_oe_n);
        end
        checks++;
        if (sram_addr !== 18'd0 || sram_wdata !== 16'h0 || mem_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wd=%h md=%h want 0 0 0", sram_addr, sram_wdata, mem_data_out);
        end
        mem_r_en_in = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_req got %b want 0", ready);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        model_md0 = 32'h0;
        model_md1 = 32'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store();
        run_mem(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0, 5, "store");
        check_trace(1'b1, 18'd4, 32'hDEADBEEF, "store");
        checks++;
        if (mem0[4] !== 16'hBEEF || mem0[5] !== 16'hDEAD) begin
            errors++;
            $display("FAIL store_sram got %h %h want BEEF DEAD", mem0[4], mem0[5]);
        end
        idle_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_load();
        run_mem(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF, 5, "load");
        // Same load held across DONE: a one-cycle DONE means it restarts at once.
        run_mem(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF, 5, "load_again");
        check_trace(1'b0, 18'd4, 32'h0, "load");
        idle_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_both();
        run_mem(1'b0, 1'b1, 1'b1, 32'd1040, 32'h12345678, 32'hFFFF_FFFF, 5, "both");
        check_trace(1'b1, 18'd8, 32'h12345678, "both");
        checks++;
        if (mem0[8] !== 16'h5678 || mem0[9] !== 16'h1234) begin
            errors++;
            $display("FAIL both_sram got %h %h want 5678 1234", mem0[8], mem0[9]);
        end
        idle_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_nonmem();
        idle_inputs();
        wb_en_in   = 1'b1;
        alu_res_in = 32'h55;
        dest_in    = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || mem_data_out !== model_md0) begin
                errors++;
                $display("FAIL nonmem_ctrl cyc%0d got ready=%b we=%b oe=%b md=%h want 1 1 1 %h",
                         i, ready, sram_we_n, sram_oe_n, mem_data_out, model_md0);
            end
            checks++;
            if (wb_en_out !== 1'b1 || mem_r_en_out !== 1'b0 || alu_res_out !== 32'h55 || dest_out !== 4'd3) begin
                errors++;
                $display("FAIL nonmem_pass cyc%0d got wb=%b r=%b alu=%h dest=%h want 1 0 55 3",
                         i, wb_en_out, mem_r_en_out, alu_res_out, dest_out);
            end
        end
        idle_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_store();
        mem_w_en_in = 1'b1;
        alu_res_in  = 32'd1048;
        val_r_m_in  = 32'hA5A55A5A;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sram_we_n !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre_we got %b want 0", sram_we_n);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_addr !== 18'd0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pins got we=%b oe=%b addr=%0d ready=%b want 1 1 0 0",
                     sram_we_n, sram_oe_n, sram_addr, ready);
        end
        checks++;
        if (mem_data_out !== 32'h0) begin
            errors++;
            $display("FAIL midrst_md got %h want 0", mem_data_out);
        end
        idle_inputs();
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready_idle got %b want 1", ready);
        end
        model_md0 = 32'h0;
        model_md1 = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        run_mem(1'b1, 1'b0, 1'b1, 32'd1056, 32'hCAFEF00D, 32'h0, 3, "b2b_store");
        run_mem(1'b1, 1'b1, 1'b0, 32'd1056, 32'h0, 32'hCAFEF00D, 3, "b2b_load");
        checks++;
        if (mem1[16] !== 16'hF00D || mem1[17] !== 16'hCAFE) begin
            errors++;
            $display("FAIL b2b_sram got %h %h want F00D CAFE", mem1[16], mem1[17]);
        end
        idle_inputs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_both();
        test_nonmem();
        test_reset_mid_store();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
Memory stage of the ARM pipeline. It sits directly downstream of the EXE stage register and consumes its outputs: wb/mem enables, ALU result used as the address, Val_Rm used as store data, and destination. Each 32-bit load/store is performed as two 16-bit accesses to an external SRAM with programmable wait states. While an access is in progress, ready is held low so the pipeline freezes. Results pass on to the MEM stage register.

Parameters:
SRAM_ADDR_W, 18, SRAM half-word address width
WAIT_CYCLES, 2, cycles each half-word access is held (>=1)
ADDR_OFFSET, 1024, byte address mapped to SRAM half-word 0

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
wb_en_in  in  1  write-back enable from EXE stage register
mem_r_en_in  in  1  load request
mem_w_en_in  in  1  store request
alu_res_in  in  32  byte address (load/store) or ALU result
val_r_m_in  in  32  store data
dest_in  in  4  destination register
wb_en_out  out  1  = wb_en_in (combinational)
mem_r_en_out  out  1  = mem_r_en_in (combinational)
alu_res_out  out  32  = alu_res_in (combinational)
dest_out  out  4  = dest_in (combinational)
mem_data_out  out  32  last completed load word, registered
ready  out  1  0 = freeze all upstream stages and stage registers
sram_addr  out  SRAM_ADDR_W  SRAM half-word address
sram_wdata  out  16  SRAM write data
sram_rdata  in  16  SRAM read data, valid while sram_oe_n=0
sram_we_n  out  1  SRAM write strobe, active-low
sram_oe_n  out  1  SRAM output enable, active-low

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, wait counter=0, mem_data_out=0, captured low half=0.
  - sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_wdata=0.
- Request: req = mem_r_en_in | mem_w_en_in. If both are asserted, the access is a store; the load is ignored.
- Address:
  - word = (alu_res_in - ADDR_OFFSET) >> 2. Bits [1:0] are ignored.
  - LOW phase: sram_addr = {word, 1'b0}. HIGH phase: sram_addr = {word, 1'b1}.
  - Truncation is modulo 2^SRAM_ADDR_W. There is no range check.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: ready = ~req. If req, go to LOW with counter=0. Otherwise stay in IDLE.
  - LOW: ready=0. counter increments each cycle. When counter==WAIT_CYCLES-1, go to HIGH with counter=0.
    - Load: on that final cycle, capture sram_rdata into the low half.
  - HIGH: same as LOW but for the high half. On its final cycle, a load writes mem_data_out = {sram_rdata, low half}. Then go to DONE.
  - DONE: ready=1 for exactly one cycle, then go to IDLE. The pipeline advances on this edge.
- SRAM signals are combinational from the state and the stalled inputs:
  - Load phases: sram_oe_n=0, sram_we_n=1.
  - Store phases: sram_we_n=0; sram_wdata = val_r_m_in[15:0] in LOW and [31:16] in HIGH.
  - IDLE and DONE: we_n=1, oe_n=1, addr=0, wdata=0.
- Latency: a request seen in IDLE gives ready=0 for 1+2*WAIT_CYCLES cycles, then ready=1 in DONE. With defaults: 5 low cycles, ready high on the 6th.
- Back-to-back memory instructions: the next instruction appears after the DONE edge. It is seen in IDLE and restarts the sequence, with no lost cycle beyond the sequence itself.
- Inputs are stable while ready=0, because the upstream stage register is frozen. The block does not latch inputs.
- Non-memory instructions: ready stays 1, no SRAM activity, mem_data_out holds its value.
- mem_data_out changes only on completion of a load. Stores never modify it.
- Reset mid-access: the access is aborted immediately. we_n/oe_n go to 1 and the partial half-word is discarded. A store may leave the SRAM half-written; this is accepted.

Test Plan:
- Reset mid-store (release rst=0 during LOW of a store) -> sram_we_n=1 immediately, state=IDLE, ready=~req, mem_data_out=0.
- Store alu_res_in=1024+8, val_r_m_in=0xDEADBEEF:
  - SRAM writes 0xBEEF to addr 4 and 0xDEAD to addr 5, with we_n low for 2 cycles each.
  - ready pattern: 0,0,0,0,0,1.
- Load from 1032 with SRAM model addr4=0xBEEF, addr5=0xDEAD -> mem_data_out=0xDEADBEEF in DONE, ready high exactly 1 cycle.
- Non-memory instruction (wb_en_in=1, alu_res_in=0x55, dest_in=3) -> ready=1 continuously, outputs pass through unchanged, no SRAM strobes.
- Back-to-back store then load to the same address with WAIT_CYCLES=1 -> each takes 3 freeze cycles; the load returns the stored word.
- mem_r_en_in and mem_w_en_in both 1 -> store performed, mem_data_out unchanged.
